traffic_interval_timer: RTL

Interval timer that directly feeds the two-road traffic-light controller FSM. It consumes the controller's timer-run request, which is high while a green phase is timing. It divides clk down to one-second ticks, counts elapsed seconds, and returns the timer_a and timer_b expiry flags. Durations are programmable and latched at the start of each run so that a phase cannot be disturbed mid-count.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/traffic_interval_timer_if.sv | 24 ++
 rtl/traffic_tick_gen.sv | 35 +++
 rtl/traffic_interval_timer.sv | 82 ++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic interval timer slice.
// Contents: default widths, durations and prescaler values, the run-phase
// enum and a helper that classifies the current cycle from run and run_q.
package traffic_pkg;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned DUR_A_DEF    = 30;
  localparam int unsigned DUR_B_DEF    = 20;
  localparam int unsigned TICK_DIV_DEF = 100000000;
  localparam int unsigned TICK_DIV_SIM = 4;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_START = 2'd1,
    PH_RUN   = 2'd2
  } phase_e;

  // A start cycle is the first cycle of run high; run low is always idle.
  function automatic phase_e phase_of(input logic run, input logic run_q);
    if (!run)       return PH_IDLE;
    else if (!run_q) return PH_START;
    else            return PH_RUN;
  endfunction

endpackage

// File: rtl/traffic_interval_timer_if.sv
// Controller <-> interval timer bundle.
// Signals: run (run request), dur_a/dur_b (durations in seconds),
// timer_a/timer_b (expiry flags), and with TIMER_REMAIN_EN defined
// remain_a/remain_b (seconds left, for the countdown display).
// Modports: master = controller side, slave = timer side.
interface traffic_interval_timer_if #(
  parameter int unsigned CNT_W = traffic_pkg::CNT_W_DEF
);
  logic             run;
  logic [CNT_W-1:0] dur_a;
  logic [CNT_W-1:0] dur_b;
  logic             timer_a;
  logic             timer_b;
`ifdef TIMER_REMAIN_EN
  logic [CNT_W-1:0] remain_a;
  logic [CNT_W-1:0] remain_b;

  modport master (output run, dur_a, dur_b, input timer_a, timer_b, remain_a, remain_b);
  modport slave  (input run, dur_a, dur_b, output timer_a, timer_b, remain_a, remain_b);
`else
  modport master (output run, dur_a, dur_b, input timer_a, timer_b);
  modport slave  (input run, dur_a, dur_b, output timer_a, timer_b);
`endif
endinterface

// File: rtl/traffic_tick_gen.sv
// One-second prescaler: counts clk cycles and pulses tick for one cycle on
// the terminal count TICK_DIV-1. clr synchronously returns the count to 0
// and suppresses the tick.
// Ports: clk, reset_n (async active-low), clr, tick.
module traffic_tick_gen #(
  parameter int unsigned TICK_DIV = traffic_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned      DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] TERM  = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    tick      = 1'b0;
    if (clr) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == TERM) begin
      div_cnt_d = '0;
      tick      = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt_q <= '0;
    else          div_cnt_q <= div_cnt_d;
  end
endmodule

// File: rtl/traffic_interval_timer.sv
// Interval timer for the two-road traffic-light controller. Counts elapsed
// seconds while run is high, with durations latched on the run rising edge,
// and flags expiry of the road-A and road-B green phases.
// Ports: clk, reset_n (async active-low), bus (slave side of
// traffic_interval_timer_if: run, dur_a, dur_b in; timer_a, timer_b out).
// Optional macro TIMER_REMAIN_EN adds remain_a/remain_b countdown outputs.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  traffic_interval_timer_if.slave   bus
);
  logic             run_q, run_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] dur_a_q, dur_a_d;
  logic [CNT_W-1:0] dur_b_q, dur_b_d;
  phase_e           phase;
  logic             tick;

  assign phase = phase_of(bus.run, run_q);

  traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (phase != PH_RUN),
    .tick    (tick)
  );

  always_comb begin
    run_d     = run_q;
    sec_cnt_d = sec_cnt_q;
    dur_a_d   = dur_a_q;
    dur_b_d   = dur_b_q;
    case (phase)
      PH_START: begin
        run_d     = 1'b1;
        sec_cnt_d = '0;
        dur_a_d   = bus.dur_a;
        dur_b_d   = bus.dur_b;
      end
      PH_RUN: begin
        if (tick && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      end
      default: begin
        run_d     = 1'b0;
        sec_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      sec_cnt_q <= '0;
      dur_a_q   <= '0;
      dur_b_q   <= '0;
    end else begin
      run_q     <= run_d;
      sec_cnt_q <= sec_cnt_d;
      dur_a_q   <= dur_a_d;
      dur_b_q   <= dur_b_d;
    end
  end

  // Gating with run_q keeps the flags low in the start cycle, so a stale
  // count from the previous phase cannot expire the new one.
  always_comb begin
    bus.timer_a = run_q && (sec_cnt_q >= dur_a_q);
    bus.timer_b = run_q && (sec_cnt_q >= dur_b_q);
  end

`ifdef TIMER_REMAIN_EN
  always_comb begin
    bus.remain_a = (run_q && (dur_a_q > sec_cnt_q)) ? (dur_a_q - sec_cnt_q) : '0;
    bus.remain_b = (run_q && (dur_b_q > sec_cnt_q)) ? (dur_b_q - sec_cnt_q) : '0;
  end
`endif
endmodule
